// File: rtl/instr_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_responder_pkg
// Shared definitions for the instruction-memory responder and the cache
// memory controller that drives it: bus widths, block geometry and the
// responder FSM state encoding.
// -----------------------------------------------------------------------------
package instr_mem_responder_pkg;

    // Widths shared with the memory controller
    localparam int ADDR_WIDTH       = 8;
    localparam int MEM_DATA_WIDTH   = 32;

    // Block geometry: 10 words streamed per block, each block occupies a
    // 16-word slot so the word address is a plain {block, idx} concatenation.
    localparam int WORDS_PER_BLOCK  = 10;
    localparam int SLOT_STRIDE_LOG2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// -----------------------------------------------------------------------------
// instr_mem_responder_if
// Request/stream bus between the cache memory controller (master) and the
// instruction-memory responder (slave).
//   i_mem_req_addr   : block address of the request
//   i_mem_req_valid  : one-cycle request strobe
//   i_mem_ready      : controller ready to take the stream
//   o_mem_data       : streamed word
//   o_mem_data_valid : streamed word valid
// -----------------------------------------------------------------------------
interface instr_mem_responder_if
    import instr_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = instr_mem_responder_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = instr_mem_responder_pkg::MEM_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0]     i_mem_req_addr;
    logic                      i_mem_req_valid;
    logic                      i_mem_ready;
    logic [MEM_DATA_WIDTH-1:0] o_mem_data;
    logic                      o_mem_data_valid;

    modport master (
        output i_mem_req_addr,
        output i_mem_req_valid,
        output i_mem_ready,
        input  o_mem_data,
        input  o_mem_data_valid
    );

    modport slave (
        input  i_mem_req_addr,
        input  i_mem_req_valid,
        input  i_mem_ready,
        output o_mem_data,
        output o_mem_data_valid
    );
endinterface

// File: rtl/instr_mem_array.sv
// -----------------------------------------------------------------------------
// instr_mem_array
// Word array with one write port and one registered read port. A read and a
// write to the same word in the same cycle returns the old contents; the new
// value is readable from the next cycle. Array contents are never reset; only
// the read register clears on rst.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr          : read request; rd_data updates one edge later
//   rd_data                 : registered read data, holds when rd_en=0
// -----------------------------------------------------------------------------
module instr_mem_array #(
    parameter int WORD_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WORD_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    input  logic [WORD_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]      rd_data
);
    logic [DATA_WIDTH-1:0] words [2**WORD_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the pre-edge array gives read-old-data on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= words[rd_addr];
        end
    end
endmodule

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
// Memory-side responder for the cache memory controller. A request accepted
// in IDLE waits LATENCY cycles (holding further if the controller is not
// ready), then streams WORDS_PER_BLOCK contiguous words of the block with no
// stalls. Requests arriving while busy are discarded and flagged.
//   clk, rst        : clock, synchronous active-high reset
//   mem (slave)     : request / stream bus
//   i_wr_en/addr/data : array load port, word address {block, idx}
//   o_busy          : request in progress (WAIT, HOLD or STREAM)
//   o_req_dropped   : sticky flag, a request arrived while busy
// -----------------------------------------------------------------------------
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = instr_mem_responder_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH  = instr_mem_responder_pkg::MEM_DATA_WIDTH,
    parameter int WORDS_PER_BLOCK = instr_mem_responder_pkg::WORDS_PER_BLOCK,
    parameter int LATENCY         = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    instr_mem_responder_if.slave                                mem,
    input  logic                                                i_wr_en,
    input  logic [ADDR_WIDTH+instr_mem_responder_pkg::SLOT_STRIDE_LOG2-1:0] i_wr_addr,
    input  logic [MEM_DATA_WIDTH-1:0]                           i_wr_data,
    output logic                                                o_busy,
    output logic                                                o_req_dropped
);
    localparam int         WORD_ADDR_WIDTH = ADDR_WIDTH + SLOT_STRIDE_LOG2;
    localparam logic [3:0] LAT_INIT        = 4'(LATENCY - 1);
    localparam logic [3:0] LAST_IDX        = 4'(WORDS_PER_BLOCK - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  r_blk;
    logic [3:0]             lat_cnt;
    logic [3:0]             word_idx;
    logic                   data_valid;
    logic                   req_dropped;
    logic                   rd_en;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (mem.i_mem_req_valid) state_nxt = ST_WAIT;
            ST_WAIT:   if (lat_cnt == 4'd0) state_nxt = mem.i_mem_ready ? ST_STREAM : ST_HOLD;
            ST_HOLD:   if (mem.i_mem_ready) state_nxt = ST_STREAM;
            ST_STREAM: if (word_idx == LAST_IDX) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt  <= 4'd0;
            word_idx <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem.i_mem_req_valid) begin
                        lat_cnt  <= LAT_INIT;
                        word_idx <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                end
                ST_STREAM: begin
                    // Wrap to 0 on the last word so the next block starts clean
                    word_idx <= (word_idx == LAST_IDX) ? 4'd0 : word_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Block address is data: captured on acceptance, never cleared
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && mem.i_mem_req_valid) begin
            r_blk <= mem.i_mem_req_addr;
        end
    end

    // Valid is aligned with the registered read: the word read in a STREAM
    // cycle appears on o_mem_data after the same edge that sets valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid  <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            data_valid <= (state == ST_STREAM);
            if (mem.i_mem_req_valid && state != ST_IDLE) begin
                req_dropped <= 1'b1;
            end
        end
    end

    assign rd_en = (state == ST_STREAM);

    instr_mem_array #(
        .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH),
        .DATA_WIDTH      (MEM_DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (rd_en),
        .rd_addr ({r_blk, word_idx}),
        .rd_data (mem.o_mem_data)
    );

    assign mem.o_mem_data_valid = data_valid;
    assign o_busy               = (state != ST_IDLE);
    assign o_req_dropped        = req_dropped;
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Memory-side responder directly downstream of the cache memory controller.
- Accepts a block request as an 8-bit block address plus valid. After a programmable latency it streams the block back as 10 consecutive 32-bit words, one per cycle, with valid held high for exactly 10 contiguous cycles.
- Holds block contents in an internal word array, loaded through a simple write port. Used as the backing instruction memory in simulation and FPGA bring-up.

Parameters:
- ADDR_WIDTH, 8, block address width; array holds 2^ADDR_WIDTH blocks.
- MEM_DATA_WIDTH, 32, width of one streamed word.
- WORDS_PER_BLOCK, 10, words per block; slot stride is fixed at 16 words.
- LATENCY, 4, idle cycles between request acceptance and first data word; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_mem_req_addr  input  ADDR_WIDTH  block address from controller.
- i_mem_req_valid  input  1  request strobe; one-cycle pulse.
- i_mem_ready  input  1  controller ready to receive stream.
- i_wr_en  input  1  array write enable.
- i_wr_addr  input  ADDR_WIDTH+4  word address {block, word_idx}.
- i_wr_data  input  MEM_DATA_WIDTH  array write data.
- o_mem_data  output  MEM_DATA_WIDTH  streamed word.
- o_mem_data_valid  output  1  word valid.
- o_busy  output  1  request in progress (WAIT, HOLD or STREAM).
- o_req_dropped  output  1  sticky: a request arrived while busy.

Behaviour:
- Reset is synchronous active-high, one clock, at the rising edge with rst=1:
  - state=IDLE; o_mem_data=0, o_mem_data_valid=0, o_busy=0, o_req_dropped=0; counters=0.
  - Array contents are NOT cleared.
  - Reset mid-operation aborts the stream immediately; o_mem_data_valid is 0 on the following cycle.
- FSM states: IDLE, WAIT, HOLD, STREAM.
- IDLE:
  - i_mem_req_valid=1 at edge T → capture addr into r_blk; lat_cnt=LATENCY-1; go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: go to STREAM if i_mem_ready=1, else go to HOLD.
- HOLD:
  - Go to STREAM on the first cycle i_mem_ready=1.
- STREAM:
  - word_idx runs 0..9; o_mem_data = array[{r_blk, word_idx}], registered.
  - o_mem_data_valid=1 for exactly WORDS_PER_BLOCK consecutive cycles.
  - Not stallable: i_mem_ready is ignored once STREAM is entered.
  - After word 9 → IDLE; o_mem_data_valid drops the next cycle.
  - o_mem_data holds the last word while invalid; it does not return to 0.
- Latency with i_mem_ready=1 throughout: request at edge T → first valid word visible after edge T+LATENCY+1, last word after edge T+LATENCY+10.
- Requests while o_busy=1:
  - Ignored; o_req_dropped set and held until rst.
  - A request in the same cycle STREAM returns to IDLE is also dropped. A new request is accepted only from IDLE.
- Write port:
  - Active in every state.
  - Write and stream read to the same word in the same cycle returns OLD data; the new value is visible from the next cycle.
- Addressing and widths:
  - Word address is {block, 4-bit idx}; no multiplier.
  - Idx values 10..15 are writable but never streamed.
- o_busy is 1 in WAIT, HOLD and STREAM.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, WAIT=1, HOLD=2, STREAM=3);
  - WORDS_PER_BLOCK=10 and SLOT_STRIDE_LOG2=4;
  - MEM_DATA_WIDTH=32, ADDR_WIDTH=8, shared with the memory controller.
- One sub-module: instr_mem_array.
  - Single write port, single registered read port.
  - Read-old-data on collision.
- FSM, latency counter and word counter stay in the top module.

Test Plan:
- Reset/basic: preload block 0x05 words k=0..9 with 0xA500_0000+k; rst 2 cycles; req addr 0x05 with ready=1, LATENCY=4 → valid high exactly 10 cycles starting edge T+5, data 0xA5000000..0xA5000009 in order, o_busy low after the last word.
- Back-pressure: req 0x05 with i_mem_ready=0 until T+9 → FSM in HOLD; data starts the cycle after ready rises, still 10 contiguous words; dropping ready mid-stream changes nothing.
- Busy drop: second req 0x06 during STREAM of 0x05 → stream of 0x05 unaffected, o_req_dropped=1 and stays 1; no stream for 0x06 follows.
- Collision: during STREAM of 0x05, write 0xDEADBEEF to {0x05,3} in the same cycle word 3 is read → stream outputs 0xA5000003; a re-request later returns 0xDEADBEEF at word 3.
- Reset mid-stream: assert rst after word 4 → valid 0 the next cycle, o_busy=0, o_req_dropped=0; a new req 0x05 afterwards streams all 10 words correctly.
- Boundary: block 0xFF, LATENCY=1 build → first word at T+2; words 10..15 of the slot written with 0xFFFFFFFF never appear on o_mem_data.
